fpa_result_fifo: RTL
====================

Name: fpa_result_fifo

Overview:
- Downstream stage of the registered floating-point adder top level. Consumes each registered sum (`number_out`) tagged with a valid strobe.
- Classifies each sum as NaN, Inf, zero, subnormal or normal, and buffers sum plus class flags in a small first-word-fall-through FIFO.
- Downstream consumers drain it through a valid/ready handshake, which decouples them from the adder's one-result-per-cycle cadence.

Parameters:
- EXP_SIZE, 8 (from configuration.v `EXP_SIZE`), exponent field width.
- MANTIS_SIZE, 23 (from configuration.v `MANTIS_SIZE`), mantissa field width.
- DEPTH, 4, FIFO entries; must be a power of two and >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_number carries a sum this cycle.
- in_number  input  1+EXP_SIZE+MANTIS_SIZE  sum from the adder top level; sign is the MSB, then exponent, then mantissa.
- in_ready  output  1  FIFO can accept; equals !full.
- out_valid  output  1  head entry present; equals !empty.
- out_number  output  1+EXP_SIZE+MANTIS_SIZE  head sum.
- out_flags  output  4  head class flags {nan, inf, zero, sub}; all zero means normal.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- drop_err  output  1  sticky flag: an input was lost because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, drop_err=0.
  - Outputs then read out_valid=0 and in_ready=1.
  - out_number and out_flags are don't-care while out_valid=0.
  - Reset has priority over push and pop in the same cycle.
  - Storage array is not reset.
- Push = in_valid & in_ready.
  - Writes {in_number, class flags} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- Pop = out_ready & out_valid; rd_ptr advances modulo DEPTH.
- Output path (first-word fall-through):
  - out_number and out_flags are driven combinationally from storage[rd_ptr].
  - A word pushed at edge N is visible with out_valid=1 after edge N, so latency is 1 cycle.
  - There is no combinational path from in_* to out_*.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Empty with in_valid and out_ready both high: the push is accepted; no pop occurs because out_valid=0.
- Full (count==DEPTH): in_ready=0. A pop in the same cycle frees an entry, but in_ready stays 0 that cycle; there is no same-cycle full bypass.
- Overflow: in_valid=1 while in_ready=0 drops the word and sets drop_err=1. drop_err holds until reset.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided from count, not pointer compare.
- Classification (computed at push, stored alongside the word; exp = exponent field, man = mantissa field):
  - exp all ones, man != 0 -> nan=1.
  - exp all ones, man == 0 -> inf=1.
  - exp == 0, man == 0 -> zero=1 (either sign).
  - exp == 0, man != 0 -> sub=1.
  - otherwise -> 4'b0000.
  - Flags are mutually exclusive; at most one is set.
- Sign is not interpreted by classification; it passes through unchanged.

Test Plan:
1. Reset then idle -> out_valid=0, in_ready=1, count=0, drop_err=0.
2. Push 0x7FC00000, 0x7F800000, 0x80000000, 0x00000001 on consecutive cycles with out_ready=0 -> count=4, in_ready=0. Then hold out_ready=1 -> heads appear in order with out_flags 1000, 0100, 0010, 0001; count returns to 0.
3. Push 0x3F800000 with out_ready=1 held -> out_valid rises one cycle after the push with out_number=0x3F800000 and out_flags=0000; popped on that same cycle; count back to 0.
4. Fill to 4 entries, then assert in_valid=1 with 0x40000000 and out_ready=1 together -> pop accepted, word dropped, count=3, drop_err=1 and remains 1 until reset.
5. Steady stream: in_valid=1 and out_ready=1 for 20 cycles with count at 2 -> count stays 2, output order matches input order, pointers wrap past DEPTH with no corruption.
6. Assert rst with 3 entries stored while pushing -> next cycle count=0, out_valid=0, drop_err=0, and the concurrent push is discarded.

Source files
------------

// File: rtl/fpa_result_fifo.sv
// Classifying first-word-fall-through FIFO behind the registered FP adder.
// Each sum is stored together with its {nan, inf, zero, sub} class and drained through valid/ready.
module fpa_result_fifo #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23,
  parameter int DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     in_number,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [EXP_SIZE+MANTIS_SIZE:0]     out_number,
  output logic [3:0]                        out_flags,
  input  logic                              out_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              drop_err
);

  localparam int W     = 1 + EXP_SIZE + MANTIS_SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W+3:0]       storage [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_err_q, drop_err_d;
  logic               full, empty, push, pop;
  logic [EXP_SIZE-1:0]    exp_f;
  logic [MANTIS_SIZE-1:0] man_f;
  logic [3:0]             in_flags;

  assign exp_f = in_number[W-2 -: EXP_SIZE];
  assign man_f = in_number[MANTIS_SIZE-1:0];

  // Sign bit is deliberately ignored: -0 is still zero, -Inf still Inf.
  always_comb begin
    in_flags = 4'b0000;
    if (&exp_f) begin
      if (|man_f) in_flags = 4'b1000;
      else        in_flags = 4'b0100;
    end else if (exp_f == '0) begin
      if (|man_f) in_flags = 4'b0001;
      else        in_flags = 4'b0010;
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // A pop in the same cycle does not rescue a word offered while full.
    if (in_valid && full) drop_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !rst) storage[wr_ptr_q] <= {in_flags, in_number};
  end

  assign out_number = storage[rd_ptr_q][W-1:0];
  assign out_flags  = storage[rd_ptr_q][W+3:W];
  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign count      = count_q;
  assign drop_err   = drop_err_q;

endmodule
